mem_port_arbiter: RTL

- Shares the single-port 16-bit unified memory between the instruction-fetch stage and the load/store stage of the 16-bit MIPS core.
- Grants at most one access per cycle. Data access has priority, with a bounded-starvation override for fetch.
- Routes the 1-cycle-latency read data back to the requester that issued the read.
- Sits between the core's PC/fetch logic, the MEM stage and the memory macro. The core uses the stall outputs to freeze its PC and pipeline.

---
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_port_arbiter.sv | 52 +++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and memory-macro signals of the shared memory port
interface mem_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_stall;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_stall;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_stall, if_rvalid, if_rdata,
        input  d_gnt, d_stall, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_stall, if_rvalid, if_rdata,
        output d_gnt, d_stall, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and load/store, data first with
// a bounded-starvation override for fetch, and routes 1-cycle read data back to its requester.
module mem_port_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int STARVE_MAX = 4
) (
    input logic             clk,
    input logic             rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DATA} owner_t;

    owner_t        r_owner;
    logic [3:0]    r_streak;
    logic          w_if_gnt;
    logic          w_d_gnt;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_rdata;

    // Data wins unless fetch has already lost STARVE_MAX conflicts in a row
    always_comb begin
        w_d_gnt  = ~rst & bus.d_req & (~bus.if_req | (r_streak < 4'(STARVE_MAX)));
        w_if_gnt = ~rst & bus.if_req & ~w_d_gnt;
        w_addr   = w_d_gnt ? bus.d_addr : bus.if_addr;
        w_rdata  = bus.mem_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_streak <= 4'd0;
            r_owner  <= OWN_NONE;
        end else begin
            r_streak <= (w_if_gnt | ~bus.if_req) ? 4'd0 :
                        (w_d_gnt && r_streak != 4'hF) ? r_streak + 4'd1 : r_streak;
            r_owner  <= w_if_gnt ? OWN_IF : (w_d_gnt & ~bus.d_we) ? OWN_DATA : OWN_NONE;
        end
    end

    assign bus.if_gnt    = w_if_gnt;
    assign bus.d_gnt     = w_d_gnt;
    assign bus.if_stall  = bus.if_req & ~w_if_gnt;
    assign bus.d_stall   = bus.d_req & ~w_d_gnt;
    assign bus.mem_en    = w_if_gnt | w_d_gnt;
    assign bus.mem_we    = w_d_gnt & bus.d_we;
    assign bus.mem_addr  = w_addr;
    assign bus.mem_wdata = bus.d_wdata;
    assign bus.if_rvalid = (r_owner == OWN_IF);
    assign bus.d_rvalid  = (r_owner == OWN_DATA);
    assign bus.if_rdata  = w_rdata;
    assign bus.d_rdata   = w_rdata;
endmodule
